// File: rtl/kypd_entry_ctrl.sv
// Keypad entry controller: debounces decoder codes, assembles A op B
// from decimal keys and hands the request to the calculator core.
module kypd_entry_ctrl #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int MAX_DIGITS    = 4,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        key_code,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [1:0]        op_sel,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [DATA_W-1:0] disp_val,
    output logic              key_strobe
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [4:0] NONE = 5'h1F;

    typedef enum logic [1:0] {S_A, S_B, S_REQ} state_t;

    state_t            state, state_n;
    logic [4:0]        cur, acc_code, kc_n;
    logic [SW-1:0]     stab;
    logic              stable, press;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] op_a_n, op_b_n, disp_n;
    logic [DATA_W-1:0] acc_in, acc_nxt;
    logic [1:0]        op_sel_n;
    logic              req_valid_n;
    logic              is_dig, is_op, is_ent, is_clr;

    // Undefined decoder codes fold onto "no key"
    assign kc_n   = key_code[4] ? NONE : key_code;
    assign stable = (stab == SW'(STABLE_CYCLES));
    assign press  = stable && (cur != acc_code) && (cur != NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= NONE;
            acc_code   <= NONE;
            stab       <= '0;
            key_strobe <= 1'b0;
        end else begin
            cur        <= kc_n;
            key_strobe <= press;
            if (kc_n != cur)
                stab <= '0;
            else if (!stable)
                stab <= stab + SW'(1);
            if (stable && (cur != acc_code))
                acc_code <= cur;
        end
    end

    assign is_dig = (cur[3:0] <= 4'd9);
    assign is_op  = (cur[3:0] >= 4'hA) && (cur[3:0] <= 4'hD);
    assign is_ent = (cur[3:0] == 4'hE);
    assign is_clr = (cur[3:0] == 4'hF);

    assign acc_in  = (state == S_A) ? op_a : op_b;
    assign acc_nxt = DATA_W'(acc_in * DATA_W'(10)) + DATA_W'(cur[3:0]);

    always_comb begin
        state_n     = state;
        op_a_n      = op_a;
        op_b_n      = op_b;
        op_sel_n    = op_sel;
        cnt_n       = cnt;
        req_valid_n = req_valid;
        if (state == S_REQ) begin
            if (req_valid && req_ready) begin
                req_valid_n = 1'b0;
                op_a_n      = '0;
                op_b_n      = '0;
                op_sel_n    = '0;
                cnt_n       = '0;
                state_n     = S_A;
            end
        end else if (press) begin
            unique case (1'b1)
                is_dig: begin
                    if (cnt != CW'(MAX_DIGITS)) begin
                        cnt_n = cnt + CW'(1);
                        if (state == S_A)
                            op_a_n = acc_nxt;
                        else
                            op_b_n = acc_nxt;
                    end
                end
                is_op: begin
                    op_sel_n = 2'(cur[3:0] - 4'hA);
                    if (state == S_A) begin
                        op_b_n  = '0;
                        cnt_n   = '0;
                        state_n = S_B;
                    end
                end
                is_ent: begin
                    if ((state == S_B) && (cnt != '0)) begin
                        req_valid_n = 1'b1;
                        state_n     = S_REQ;
                    end
                end
                is_clr: begin
                    op_a_n   = '0;
                    op_b_n   = '0;
                    op_sel_n = '0;
                    cnt_n    = '0;
                    state_n  = S_A;
                end
                default: ;
            endcase
        end
    end

    // Display tracks the current entry, one cycle behind the state
    always_comb begin
        disp_n = op_b;
        unique case (state)
            S_A:     disp_n = op_a;
            S_B:     disp_n = (cnt != '0) ? op_b : op_a;
            default: disp_n = op_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            cnt       <= '0;
            req_valid <= 1'b0;
            disp_val  <= '0;
        end else begin
            state     <= state_n;
            op_a      <= op_a_n;
            op_b      <= op_b_n;
            op_sel    <= op_sel_n;
            cnt       <= cnt_n;
            req_valid <= req_valid_n;
            disp_val  <= disp_n;
        end
    end

endmodule
